// File: rtl/z_ram_reader.sv
// Read sequencer for the z-value RAM: walks (base, len) through a registered-address
// read port and streams words on valid/ready. Optional stall counter: ZRD_STALL_CNT_EN.
module z_ram_reader #(
  parameter int D_WIDTH = 4,
  parameter int A_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]   len,
  output logic [A_WIDTH-1:0] r_addr,
  input  logic [D_WIDTH-1:0] ram_data,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
`ifdef ZRD_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state, state_nx;
  logic [A_WIDTH-1:0] ptr, addr_q;
  logic [A_WIDTH:0]   remaining;
  logic               inflight, inflight_last;
  logic [1:0]         fifo_count;
  logic [D_WIDTH-1:0] data0, data1;
  logic               last0, last1;
  logic               pop, issue, accept, done_nx;
  logic [2:0]         occ;

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = data0;
  assign out_last  = last0;
  assign busy      = (state != IDLE);
  assign pop       = out_valid && out_ready;
  assign r_addr    = issue ? ptr : addr_q;

  // Words already buffered or on their way out of the RAM, net of this cycle's pop.
  assign occ = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    issue    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (len == '0) done_nx = 1'b1;
          else           state_nx = RUN;
        end
      end
      RUN: begin
        if (remaining != '0 && occ < 3'd2) begin
          issue = 1'b1;
          if (remaining == (A_WIDTH+1)'(1)) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && out_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      ptr           <= '0;
      addr_q        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_count    <= 2'd0;
      data0         <= '0;
      data1         <= '0;
      last0         <= 1'b0;
      last1         <= 1'b0;
    end else begin
      state         <= state_nx;
      done          <= done_nx;
      inflight      <= issue;
      inflight_last <= issue && (remaining == (A_WIDTH+1)'(1));
      if (accept) begin
        ptr       <= base_addr;
        remaining <= len;
      end else if (issue) begin
        ptr       <= ptr + A_WIDTH'(1);
        remaining <= remaining - (A_WIDTH+1)'(1);
        addr_q    <= ptr;
      end
      // Shift FIFO: entry 0 is the head; last1 is kept 0 whenever entry 1 is empty.
      case ({inflight, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            data0 <= ram_data;
            last0 <= inflight_last;
          end else begin
            data1 <= ram_data;
            last1 <= inflight_last;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          data0      <= data1;
          last0      <= last1;
          last1      <= 1'b0;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            data0 <= ram_data;
            last0 <= inflight_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= ram_data;
            last1 <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ZRD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= 16'd0;
    else if (accept)
      stall_cnt <= 16'd0;
    else if (busy && out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(inflight && !pop && fifo_count == 2'd2));

endmodule

// File: tb/tb_z_ram_reader.sv
// Self-checking bench for z_ram_reader: directed bursts plus 200 random bursts
// scored against RAM[(base+i) mod 16] with random out_ready.
module tb_z_ram_reader;
  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] ram_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef ZRD_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  logic [DW-1:0] mem [DEPTH];
  int compared   = 0;
  int mismatched = 0;

  z_ram_reader #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .r_addr(r_addr),
    .ram_data(ram_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done)
`ifdef ZRD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM model with a registered read address
  always @(posedge clk) ram_data <= mem[r_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] b, input int i);
    logic [AW-1:0] a;
    a = b + AW'(i);
    return mem[a];
  endfunction

  // Entered just after a rising edge with the DUT idle; returns the same way.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int ready_pct,
                           input int stall_lo, input int stall_hi, input int poke_cyc,
                           output int done_cyc, output int stalls);
    int beats, dones;
    logic prev_hold, prev_last;
    logic [DW-1:0] prev_data;
    beats = 0; dones = 0; done_cyc = -1; stalls = 0;
    prev_hold = 1'b0; prev_last = 1'b0; prev_data = '0;
    start = 1'b1; base_addr = b; len = l; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc >= stall_lo && cyc <= stall_hi) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) < ready_pct);
      if (cyc == poke_cyc) begin
        start = 1'b1; base_addr = ~b; len = 1;
      end
      @(negedge clk);
      if (cyc == 1) check("busy_after_start", busy, l != 0);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (cyc == stall_hi && stall_lo > 0) check("bp_r_addr", r_addr, AW'(b + AW'(1)));
      if (out_valid && out_ready) begin
        check("beat_data", out_data, ref_word(b, beats));
        check("beat_last", out_last, beats == int'(l) - 1);
        beats++;
      end
      if (out_valid && !out_ready) stalls++;
      if (done) begin
        check("busy_at_done", busy, 0);
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    check("beat_count", beats, l);
    check("done_count", dones, 1);
`ifdef ZRD_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stalls);
`endif
  endtask

  initial begin
    int dc, st;
    logic [3:0] key;
    key = 4'($urandom);
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) ^ key;
    rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    #2;
    check("rst_r_addr", r_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Cycle-exact burst: base 3, len 5, always ready
    start = 1'b1; base_addr = 4'd3; len = 5'd5; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 5) check("t1_r_addr", r_addr, c + 2);
      check("t1_valid", out_valid, c >= 3 && c <= 7);
      if (c >= 3 && c <= 7) check("t1_data", out_data, mem[c]);
      check("t1_last", out_last, c == 7);
      check("t1_busy", busy, c <= 7);
      check("t1_done", done, c == 8);
      @(posedge clk); #1;
    end

    // Address wrap
    run_burst(4'd14, 5'd4, 100, 0, -1, -1, dc, st);
    check("wrap_done_cycle", dc, 7);

    // Backpressure in cycles 3..9
    run_burst(4'd5, 5'd8, 100, 3, 9, -1, dc, st);
    check("bp_done_cycle", dc, 18);
    check("bp_stalls", st, 7);

    // Zero-length burst
    run_burst(4'd9, 5'd0, 100, 0, -1, -1, dc, st);
    check("len0_done_cycle", dc, 1);

    // Start while busy is ignored
    run_burst(4'd2, 5'd6, 100, 0, -1, 3, dc, st);
    check("poke_done_cycle", dc, 9);

    // Reset at cycle 4 of a len=10 burst
    start = 1'b1; base_addr = 4'd2; len = 5'd10; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("mid_rst_r_addr", r_addr, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", done, 0);
    run_burst(4'd0, 5'd2, 100, 0, -1, -1, dc, st);
    check("post_rst_done_cycle", dc, 5);

    // Random bursts with random backpressure
    for (int n = 0; n < 200; n++) begin
      run_burst(AW'($urandom_range(DEPTH - 1)), (AW+1)'($urandom_range(DEPTH)),
                $urandom_range(100, 30), 0, -1, -1, dc, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
